// File: rtl/regfile_wb_pkg.sv
// Shared constants, writeback payload type and round-robin index helper
// for the register-file writeback arbiter.
package regfile_wb_pkg;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_FPU = 1;
    localparam int unsigned REQ_LD  = 2;
    localparam int unsigned NREQ    = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_AW  = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              is_float;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // (ptr + step) mod 3 for ptr in 0..2 and step in 1..3
    function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input logic [1:0] step);
        logic [2:0] s;
        s = 3'(ptr) + 3'(step);
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus from the three requesters (ALU, FPU, load) to the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NREQ   = regfile_wb_pkg::NREQ,
    parameter int unsigned DATA_W = regfile_wb_pkg::DATA_W,
    parameter int unsigned REG_AW = regfile_wb_pkg::REG_AW
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*REG_AW-1:0] req_reg;
    logic [NREQ-1:0]        req_float;
    logic [NREQ*DATA_W-1:0] req_data;

    modport master (output req_valid, req_reg, req_float, req_data, input req_ready);
    modport slave  (input req_valid, req_reg, req_float, req_data, output req_ready);
endinterface

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter; r_ptr remembers the last grant so the search
// starts just after it.
module rr_arbiter3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_valid,
    output logic [2:0] o_grant,
    output logic [1:0] o_grant_idx
);
    import regfile_wb_pkg::*;

    logic [1:0] r_ptr;
    logic [1:0] w_idx;
    logic [1:0] w_cand;
    logic       w_found;
    logic [2:0] w_grant;

    // Search rr_ptr+1, rr_ptr+2, rr_ptr; grants are suppressed while in reset
    always_comb begin
        w_grant = '0;
        w_idx   = r_ptr;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= 3; k++) begin
            w_cand = rr_idx(r_ptr, 2'(k));
            if (!w_found && i_valid[w_cand]) begin
                w_found         = 1'b1;
                w_idx           = w_cand;
                w_grant[w_cand] = 1'b1;
            end
        end
        if (!rst_n) begin
            w_grant = '0;
            w_found = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 2'd2;
        end else if (w_found) begin
            r_ptr <= w_idx;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among ALU/FPU/load and tracks pending writes.
// Optional macro WB_FWD_EN adds writeback-stage forwarding outputs.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = regfile_wb_pkg::DATA_W,
    parameter int unsigned REG_AW = regfile_wb_pkg::REG_AW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   bus,
    input  logic                  set_valid,
    input  logic [REG_AW-1:0]     set_reg,
    input  logic                  set_float,
    input  logic [REG_AW-1:0]     q_reg1,
    input  logic [REG_AW-1:0]     q_reg2,
    input  logic                  q_float,
    output logic                  q_busy1,
    output logic                  q_busy2,
`ifdef WB_FWD_EN
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DATA_W-1:0]     fwd_data,
`endif
    output logic [REG_AW-1:0]     wb_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_regwrite,
    output logic                  wb_float
);
    import regfile_wb_pkg::*;

    localparam int unsigned NREGS = 1 << REG_AW;

    logic [NREQ-1:0]   w_grant;
    logic [1:0]        w_grant_idx;
    logic              w_xfer;
    wb_req_t           w_sel;
    logic [NREGS-1:0]  r_pend_i, r_pend_f;
    logic [NREGS-1:0]  w_pend_i_nxt, w_pend_f_nxt;
    logic [REG_AW-1:0] r_wb_reg;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_regwrite, r_wb_float;
    logic              w_busy1_raw, w_busy2_raw;

    rr_arbiter3 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (bus.req_valid),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign bus.req_ready = w_grant;
    assign w_xfer        = |w_grant;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel.rd       = bus.req_reg[i*REG_AW +: REG_AW];
                w_sel.is_float = bus.req_float[i];
                w_sel.data     = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register 0 is granted and captured but never written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_reg      <= '0;
            r_wb_data     <= '0;
            r_wb_float    <= 1'b0;
            r_wb_regwrite <= 1'b0;
        end else if (w_xfer) begin
            r_wb_reg      <= w_sel.rd;
            r_wb_data     <= w_sel.data;
            r_wb_float    <= w_sel.is_float;
            r_wb_regwrite <= (w_sel.rd != '0);
        end else begin
            r_wb_regwrite <= 1'b0;
        end
    end

    // Clear on writeback first, then set, so a same-edge set wins
    always_comb begin
        w_pend_i_nxt = r_pend_i;
        w_pend_f_nxt = r_pend_f;
        if (r_wb_regwrite) begin
            if (r_wb_float) w_pend_f_nxt[r_wb_reg] = 1'b0;
            else            w_pend_i_nxt[r_wb_reg] = 1'b0;
        end
        if (set_valid && (set_reg != '0)) begin
            if (set_float) w_pend_f_nxt[set_reg] = 1'b1;
            else           w_pend_i_nxt[set_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_i <= '0;
            r_pend_f <= '0;
        end else begin
            r_pend_i <= w_pend_i_nxt;
            r_pend_f <= w_pend_f_nxt;
        end
    end

    assign w_busy1_raw = q_float ? r_pend_f[q_reg1] : r_pend_i[q_reg1];
    assign w_busy2_raw = q_float ? r_pend_f[q_reg2] : r_pend_i[q_reg2];

`ifdef WB_FWD_EN
    // A register being written this cycle is forwarded instead of reported busy
    assign fwd_hit1 = r_wb_regwrite && (r_wb_reg == q_reg1) && (r_wb_float == q_float) && (q_reg1 != '0);
    assign fwd_hit2 = r_wb_regwrite && (r_wb_reg == q_reg2) && (r_wb_float == q_float) && (q_reg2 != '0);
    assign fwd_data = r_wb_data;
    assign q_busy1  = w_busy1_raw && !fwd_hit1;
    assign q_busy2  = w_busy2_raw && !fwd_hit2;
`else
    assign q_busy1  = w_busy1_raw;
    assign q_busy2  = w_busy2_raw;
`endif

    assign wb_reg      = r_wb_reg;
    assign wb_data     = r_wb_data;
    assign wb_regwrite = r_wb_regwrite;
    assign wb_float    = r_wb_float;

endmodule
